// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcodes,
// functs, ALU operations, memory read modes and error codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_SLL  = 3'd2,
    ALU_SRL  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_SLTU = 3'd7
  } alu_sel_t;

  typedef enum logic [1:0] {
    MR_NONE   = 2'd0,
    MR_WORD   = 2'd1,
    MR_HALF_S = 2'd2,
    MR_HALF_U = 2'd3
  } mem_read_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational instruction classifier: picks the EXEC-phase ALU operation
// and flags any opcode/funct combination the datapath cannot execute.
module mc_alu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_sel,
  output logic       o_legal
);

  always_comb begin
    o_alu_sel = ALU_ADD;
    o_legal   = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_alu_sel = ALU_ADD;
          FN_SUB:  o_alu_sel = ALU_SUB;
          FN_SLL:  o_alu_sel = ALU_SLL;
          FN_SRL:  o_alu_sel = ALU_SRL;
          FN_AND:  o_alu_sel = ALU_AND;
          FN_OR:   o_alu_sel = ALU_OR;
          FN_SLT:  o_alu_sel = ALU_SLT;
          FN_SLTU: o_alu_sel = ALU_SLTU;
          default: o_legal   = 1'b0;
        endcase
      end
      // Address generation for memory ops shares the ADD path with ADDI.
      OP_LW, OP_LH, OP_LHU, OP_SW, OP_ADDI: o_alu_sel = ALU_ADD;
      OP_BEQ:  o_alu_sel = ALU_SUB;
      OP_ANDI: o_alu_sel = ALU_AND;
      OP_ORI:  o_alu_sel = ALU_OR;
      default: o_legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT) driving datapath
// strobes and a variable-latency memory port with timeout-based error halt.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic [1:0]          mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_sel,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                halted,
  output logic [1:0]          err,
  output logic [RETIRE_W-1:0] retired,
  output logic [2:0]          state
);

  // Memory handshake: mem_req with iord/mem_read/mem_write holds steady until
  // a rising clk edge samples mem_ready=1; that edge completes the transfer.

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_started;
  logic [TW-1:0]       r_tmo;
  logic [1:0]          r_err;
  logic [RETIRE_W-1:0] r_retired;

  logic                w_tmo_hit;
  logic                w_retire;
  logic                w_err_set;
  logic [1:0]          w_err_code;
  logic [2:0]          w_alu_sel;
  logic                w_legal;

  mc_alu_decode u_alu_decode (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_alu_sel (w_alu_sel),
    .o_legal   (w_legal)
  );

  // Only meaningful in states that are currently requesting memory.
  assign w_tmo_hit = !mem_ready && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_FETCH;
      r_started <= 1'b0;
      r_tmo     <= '0;
      r_err     <= ERR_NONE;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      if (mem_req && !mem_ready && !w_tmo_hit) r_tmo <= r_tmo + TW'(1);
      else                                      r_tmo <= '0;
      if (w_err_set) r_err <= w_err_code;
      if (w_retire)  r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = ERR_NONE;
    mem_req     = 1'b0;
    iord        = 1'b0;
    mem_read    = MR_NONE;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    alu_sel     = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        alu_src_b = SRCB_FOUR;
        // Gated so nothing is requested until one clean edge after reset.
        if (r_started) begin
          mem_req  = 1'b1;
          mem_read = MR_WORD;
          if (mem_ready) begin
            ir_write    = 1'b1;
            pc_write    = 1'b1;
            w_state_nxt = ST_DECODE;
          end else if (w_tmo_hit) begin
            w_state_nxt = ST_HALT;
            w_err_set   = 1'b1;
            w_err_code  = ERR_TIMEOUT;
          end
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        if (w_legal) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_HALT;
          w_err_set   = 1'b1;
          w_err_code  = ERR_ILLEGAL;
        end
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_sel   = w_alu_sel;
        case (opcode)
          OP_RTYPE: begin
            alu_src_b   = SRCB_RT;
            w_state_nxt = ST_WB;
          end
          OP_LW, OP_LH, OP_LHU, OP_SW: begin
            alu_src_b   = SRCB_IMM;
            w_state_nxt = ST_MEM;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            alu_src_b   = SRCB_IMM;
            w_state_nxt = ST_WB;
          end
          OP_BEQ: begin
            alu_src_b   = SRCB_RT;
            pc_src      = 1'b1;
            pc_write    = zero;
            w_state_nxt = ST_FETCH;
            w_retire    = 1'b1;
          end
          default: begin
            w_state_nxt = ST_HALT;
            w_err_set   = 1'b1;
            w_err_code  = ERR_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        case (opcode)
          OP_LW:   mem_read  = MR_WORD;
          OP_LH:   mem_read  = MR_HALF_S;
          OP_LHU:  mem_read  = MR_HALF_U;
          OP_SW:   mem_write = 1'b1;
          default: mem_read  = MR_NONE;
        endcase
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            w_state_nxt = ST_FETCH;
            w_retire    = 1'b1;
          end else begin
            w_state_nxt = ST_WB;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_HALT;
          w_err_set   = 1'b1;
          w_err_code  = ERR_TIMEOUT;
        end
      end
      ST_WB: begin
        reg_write   = 1'b1;
        reg_dst     = (opcode == OP_RTYPE);
        mem_to_reg  = is_load(opcode);
        w_state_nxt = ST_FETCH;
        w_retire    = 1'b1;
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_HALT;
    endcase
  end

  assign halted  = (r_state == ST_HALT);
  assign err     = r_err;
  assign retired = r_retired;
  assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are
// queued as stimulus is applied and checked against the DUT at the falling edge.
module tb_multicycle_control;

  localparam int W = 23;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        iord;
  logic [1:0]  mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_sel;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        halted;
  logic [1:0]  err;
  logic [31:0] retired;
  logic [2:0]  state;

  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_retired;
  int           n_assert;
  int           n_fail;

  multicycle_control #(.MEM_TIMEOUT(4), .RETIRE_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_sel    (alu_sel),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .err        (err),
    .retired    (retired),
    .state      (state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Expected control words: {state, req, iord, mem_read, mem_write, ir_write,
  // pc_write, pc_src, src_a, src_b, alu_sel, reg_write, reg_dst, mem_to_reg, halted, err}
  function automatic logic [W-1:0] mk(
    input logic [2:0] st, input logic req, input logic io, input logic [1:0] mr,
    input logic mw, input logic irw, input logic pcw, input logic pcs,
    input logic sa, input logic [1:0] sb, input logic [2:0] alu,
    input logic rw, input logic rd, input logic m2r, input logic h, input logic [1:0] e);
    return {st, req, io, mr, mw, irw, pcw, pcs, sa, sb, alu, rw, rd, m2r, h, e};
  endfunction

  function automatic logic [W-1:0] v_fetch_idle();
    return mk(3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic logic [W-1:0] v_fetch(input logic rdy);
    return mk(3'd0, 1'b1, 1'b0, 2'd1, 1'b0, rdy, rdy, 1'b0, 1'b0, 2'd1, 3'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic logic [W-1:0] v_decode();
    return mk(3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic logic [W-1:0] v_exec(input logic [1:0] sb, input logic [2:0] alu,
                                          input logic pcw, input logic pcs);
    return mk(3'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, pcw, pcs, 1'b1, sb, alu,
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic logic [W-1:0] v_mem(input logic [1:0] mr, input logic mw);
    return mk(3'd3, 1'b1, 1'b1, mr, mw, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic logic [W-1:0] v_wb(input logic rd, input logic m2r);
    return mk(3'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0,
              1'b1, rd, m2r, 1'b0, 2'd0);
  endfunction

  function automatic logic [W-1:0] v_halt(input logic [1:0] e);
    return mk(3'd5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0,
              1'b0, 1'b0, 1'b0, 1'b1, e);
  endfunction

  // Scoreboard: queue the expectation, compare at the falling edge, then
  // advance to just after the next rising edge for the following stimulus.
  task automatic cycle(input string tag, input logic [W-1:0] e);
    logic [W-1:0] got;
    logic [W-1:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    got  = {state, mem_req, iord, mem_read, mem_write, ir_write, pc_write, pc_src,
            alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst, mem_to_reg, halted, err};
    want = exp_q.pop_front();
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    reset_n     = 1'b0;
    mem_ready   = 1'b0;
    zero        = 1'b0;
    opcode      = 6'h00;
    funct       = 6'h20;
    exp_retired = '0;
    @(posedge clk);
    #1;
    cycle("reset_state", v_fetch_idle());
    check_val("reset_retired", retired, 32'd0);
    reset_n = 1'b1;
    cycle("post_reset_idle", v_fetch_idle());
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [1:0] sb, input logic [2:0] alu, input logic rd);
    opcode    = op;
    funct     = fn;
    mem_ready = 1'b1;
    cycle({tag, "_fetch"}, v_fetch(1'b1));
    cycle({tag, "_decode"}, v_decode());
    cycle({tag, "_exec"}, v_exec(sb, alu, 1'b0, 1'b0));
    cycle({tag, "_wb"}, v_wb(rd, 1'b0));
    exp_retired++;
    check_val({tag, "_retired"}, retired, exp_retired);
  endtask

  task automatic run_mem(input string tag, input logic [5:0] op, input logic [1:0] mr,
                         input logic mw, input int delay);
    opcode    = op;
    funct     = 6'h00;
    mem_ready = 1'b1;
    cycle({tag, "_fetch"}, v_fetch(1'b1));
    cycle({tag, "_decode"}, v_decode());
    cycle({tag, "_exec"}, v_exec(2'd2, 3'd0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    for (int i = 0; i < delay; i++) cycle({tag, "_mem_wait"}, v_mem(mr, mw));
    mem_ready = 1'b1;
    cycle({tag, "_mem_done"}, v_mem(mr, mw));
    if (!mw) cycle({tag, "_wb"}, v_wb(1'b0, 1'b1));
    exp_retired++;
    check_val({tag, "_retired"}, retired, exp_retired);
  endtask

  task automatic run_beq(input string tag, input logic z);
    opcode    = 6'h04;
    funct     = 6'h00;
    zero      = z;
    mem_ready = 1'b1;
    cycle({tag, "_fetch"}, v_fetch(1'b1));
    cycle({tag, "_decode"}, v_decode());
    cycle({tag, "_exec"}, v_exec(2'd0, 3'd1, z, 1'b1));
    exp_retired++;
    check_val({tag, "_retired"}, retired, exp_retired);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    do_reset();

    // ADDI, then the remaining ALU-class instructions
    run_alu("addi", 6'h08, 6'h00, 2'd2, 3'd0, 1'b0);
    run_alu("andi", 6'h0C, 6'h00, 2'd2, 3'd4, 1'b0);
    run_alu("ori",  6'h0D, 6'h00, 2'd2, 3'd5, 1'b0);
    run_alu("r_add",  6'h00, 6'h20, 2'd0, 3'd0, 1'b1);
    run_alu("r_sub",  6'h00, 6'h22, 2'd0, 3'd1, 1'b1);
    run_alu("r_sll",  6'h00, 6'h00, 2'd0, 3'd2, 1'b1);
    run_alu("r_srl",  6'h00, 6'h02, 2'd0, 3'd3, 1'b1);
    run_alu("r_and",  6'h00, 6'h24, 2'd0, 3'd4, 1'b1);
    run_alu("r_or",   6'h00, 6'h25, 2'd0, 3'd5, 1'b1);
    run_alu("r_slt",  6'h00, 6'h2A, 2'd0, 3'd6, 1'b1);
    run_alu("r_sltu", 6'h00, 6'h2B, 2'd0, 3'd7, 1'b1);

    // Loads/stores, LW with three wait cycles (ready on the 4th request cycle)
    run_mem("lw",  6'h23, 2'd1, 1'b0, 3);
    run_mem("lh",  6'h21, 2'd2, 1'b0, 1);
    run_mem("lhu", 6'h25, 2'd3, 1'b0, 0);
    run_mem("sw",  6'h2B, 2'd0, 1'b1, 2);

    // Branches taken and not taken
    run_beq("beq_taken", 1'b1);
    run_beq("beq_not_taken", 1'b0);

    // Illegal opcode halts and stays halted
    opcode    = 6'h3F;
    mem_ready = 1'b1;
    cycle("illop_fetch", v_fetch(1'b1));
    cycle("illop_decode", v_decode());
    for (int i = 0; i < 10; i++) cycle("illop_halt", v_halt(2'd1));
    check_val("illop_retired", retired, exp_retired);

    // Illegal R-type funct
    do_reset();
    opcode    = 6'h00;
    funct     = 6'h03;
    mem_ready = 1'b1;
    cycle("illfn_fetch", v_fetch(1'b1));
    cycle("illfn_decode", v_decode());
    for (int i = 0; i < 10; i++) cycle("illfn_halt", v_halt(2'd1));

    // Fetch timeout: ready on the 4th request cycle wins, then a true timeout
    do_reset();
    opcode    = 6'h08;
    funct     = 6'h00;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("tmo_edge_wait", v_fetch(1'b0));
    mem_ready = 1'b1;
    cycle("tmo_edge_ready", v_fetch(1'b1));
    cycle("tmo_edge_decode", v_decode());
    cycle("tmo_edge_exec", v_exec(2'd2, 3'd0, 1'b0, 1'b0));
    cycle("tmo_edge_wb", v_wb(1'b0, 1'b0));
    exp_retired++;
    check_val("tmo_edge_retired", retired, exp_retired);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle("tmo_wait", v_fetch(1'b0));
    for (int i = 0; i < 3; i++) cycle("tmo_halt", v_halt(2'd2));

    // Asynchronous reset in the middle of a store's MEM phase
    do_reset();
    run_alu("pre_sw_addi", 6'h08, 6'h00, 2'd2, 3'd0, 1'b0);
    opcode    = 6'h2B;
    mem_ready = 1'b1;
    cycle("arst_fetch", v_fetch(1'b1));
    cycle("arst_decode", v_decode());
    cycle("arst_exec", v_exec(2'd2, 3'd0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    cycle("arst_mem", v_mem(2'd0, 1'b1));
    #2;
    check_val("arst_mem_write_before", {31'd0, mem_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("arst_immediate", {27'd0, mem_req, mem_write, state}, 32'd0);
    exp_retired = '0;
    check_val("arst_retired", retired, exp_retired);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle("arst_release_idle", v_fetch_idle());
    mem_ready = 1'b1;
    opcode    = 6'h08;
    cycle("arst_first_req", v_fetch(1'b1));
    check_val("arst_retired_after", retired, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
